// File: rtl/mem_stage_access_unit.sv
// MEM-stage load/store controller: req/ack handshake to variable-latency data memory, min 3 cycles/access.
// Stall holds the upstream pipeline through IDLE(op) and ACCESS; DONE releases it for one cycle.
module mem_stage_access_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MEM_MemRead,
  input  logic        MEM_MemWrite,
  input  logic [1:0]  MEM_BitsIn,
  input  logic        MEM_MAS,
  input  logic [31:0] MEM_Address,
  input  logic [31:0] MEM_Rt,
  output logic        DM_Req,
  output logic        DM_We,
  output logic [31:0] DM_Addr,
  output logic [3:0]  DM_ByteEn,
  output logic [31:0] DM_WData,
  input  logic [31:0] DM_RData,
  input  logic        DM_Ack,
  output logic        Stall,
  output logic [31:0] MEM_ReadData,
  output logic        MEM_ReadValid,
  output logic        MisalignErr,
  output logic        TimeoutErr
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACCESS = 2'b01,
    S_DONE   = 2'b10
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic        merr_q, merr_d;
  logic        terr_q, terr_d;
  logic        ld_q, ld_d;
  logic        half_q, half_d;
  logic        byte_q, byte_d;
  logic        mas_q, mas_d;
  logic [1:0]  off_q, off_d;

  logic        op_present;
  logic        is_half;
  logic        is_byte;
  logic        misaligned;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] rd_shift;
  logic [15:0] rd_half;
  logic [31:0] ld_fmt;

  assign op_present = MEM_MemRead | MEM_MemWrite;
  assign is_half    = (MEM_BitsIn == 2'b01);
  assign is_byte    = (MEM_BitsIn == 2'b10);
  assign misaligned = (is_half & MEM_Address[0]) |
                      (~is_half & ~is_byte & (MEM_Address[1:0] != 2'b00));

  // Store lanes: little-endian, data replicated across all lanes.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = MEM_Rt;
    if (is_byte) begin
      st_be    = 4'b0001 << MEM_Address[1:0];
      st_wdata = {4{MEM_Rt[7:0]}};
    end else if (is_half) begin
      st_be    = MEM_Address[1] ? 4'b1100 : 4'b0011;
      st_wdata = {2{MEM_Rt[15:0]}};
    end
  end

  // Load formatting uses the size/offset captured at issue, not the live inputs.
  assign rd_shift = DM_RData >> {off_q, 3'b000};
  assign rd_half  = off_q[1] ? DM_RData[31:16] : DM_RData[15:0];

  always_comb begin
    ld_fmt = DM_RData;
    if (byte_q) begin
      ld_fmt = {{24{mas_q & rd_shift[7]}}, rd_shift[7:0]};
    end else if (half_q) begin
      ld_fmt = {{16{mas_q & rd_half[15]}}, rd_half};
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    merr_d   = 1'b0;
    terr_d   = 1'b0;
    ld_d     = ld_q;
    half_d   = half_q;
    byte_d   = byte_q;
    mas_d    = mas_q;
    off_d    = off_q;
    Stall    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (op_present) begin
          Stall = 1'b1;
          if (misaligned) begin
            state_d = S_DONE;
            merr_d  = 1'b1;
            rdata_d = 32'd0;
          end else begin
            state_d = S_ACCESS;
            cnt_d   = 16'd0;
            req_d   = 1'b1;
            we_d    = MEM_MemWrite;
            addr_d  = {MEM_Address[31:2], 2'b00};
            be_d    = MEM_MemWrite ? st_be : 4'b0000;
            wdata_d = MEM_MemWrite ? st_wdata : 32'd0;
            ld_d    = MEM_MemRead & ~MEM_MemWrite;
            half_d  = is_half;
            byte_d  = is_byte;
            mas_d   = MEM_MAS;
            off_d   = MEM_Address[1:0];
          end
        end
      end

      S_ACCESS: begin
        Stall = 1'b1;
        // Ack on the final counted cycle still completes normally.
        if (DM_Ack) begin
          state_d = S_DONE;
          req_d   = 1'b0;
          if (ld_q) begin
            rdata_d  = ld_fmt;
            rvalid_d = 1'b1;
          end
        end else if (cnt_q == TO_LAST) begin
          state_d = S_DONE;
          req_d   = 1'b0;
          terr_d  = 1'b1;
          rdata_d = 32'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 16'd0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 32'd0;
      be_q     <= 4'd0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      rvalid_q <= 1'b0;
      merr_q   <= 1'b0;
      terr_q   <= 1'b0;
      ld_q     <= 1'b0;
      half_q   <= 1'b0;
      byte_q   <= 1'b0;
      mas_q    <= 1'b0;
      off_q    <= 2'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      merr_q   <= merr_d;
      terr_q   <= terr_d;
      ld_q     <= ld_d;
      half_q   <= half_d;
      byte_q   <= byte_d;
      mas_q    <= mas_d;
      off_q    <= off_d;
    end
  end

  assign DM_Req        = req_q;
  assign DM_We         = we_q;
  assign DM_Addr       = addr_q;
  assign DM_ByteEn     = be_q;
  assign DM_WData      = wdata_q;
  assign MEM_ReadData  = rdata_q;
  assign MEM_ReadValid = rvalid_q;
  assign MisalignErr   = merr_q;
  assign TimeoutErr    = terr_q;

endmodule

// File: tb/tb_mem_stage_access_unit.sv
// Bench for mem_stage_access_unit: directed table, reset/late-ack sequences, randomized ops vs. a transaction model.
module tb_mem_stage_access_unit;

  localparam int TO = 4;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        MEM_MemRead, MEM_MemWrite, MEM_MAS;
  logic [1:0]  MEM_BitsIn;
  logic [31:0] MEM_Address, MEM_Rt;
  logic        DM_Req, DM_We;
  logic [31:0] DM_Addr, DM_WData, DM_RData;
  logic [3:0]  DM_ByteEn;
  logic        DM_Ack;
  logic        Stall;
  logic [31:0] MEM_ReadData;
  logic        MEM_ReadValid, MisalignErr, TimeoutErr;

  mem_stage_access_unit #(.TIMEOUT(TO)) dut (
    .Clk(Clk), .Reset(Reset),
    .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
    .MEM_BitsIn(MEM_BitsIn), .MEM_MAS(MEM_MAS),
    .MEM_Address(MEM_Address), .MEM_Rt(MEM_Rt),
    .DM_Req(DM_Req), .DM_We(DM_We), .DM_Addr(DM_Addr),
    .DM_ByteEn(DM_ByteEn), .DM_WData(DM_WData),
    .DM_RData(DM_RData), .DM_Ack(DM_Ack),
    .Stall(Stall), .MEM_ReadData(MEM_ReadData),
    .MEM_ReadValid(MEM_ReadValid), .MisalignErr(MisalignErr),
    .TimeoutErr(TimeoutErr)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [1:0]  bits;
    logic        mas;
    logic [31:0] addr;
    logic [31:0] rt;
    logic [31:0] rdata;
    int          ack_at;   // ACCESS cycle index carrying Ack, -1 = never
    logic [31:0] e_addr;
    logic        e_we;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    int          e_stall;
    int          e_req;
    logic        e_rv;
    logic        e_merr;
    logic        e_terr;
    logic [31:0] e_rdout;
  } vec_t;

  int   checks = 0;
  int   failures = 0;
  bit   in_done = 1'b0;
  logic [31:0] exp_rdout = 32'd0;
  vec_t tbl [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Transaction-level expectation from size/offset arithmetic.
  function automatic vec_t model(input vec_t v, input logic [31:0] prev);
    vec_t r;
    int nb, off;
    bit mis, ok, load;
    longint raw, lim;
    r = v;
    nb   = (v.bits == 2'b01) ? 2 : (v.bits == 2'b10) ? 1 : 4;
    off  = int'(v.addr % 4);
    mis  = (v.addr % nb) != 0;
    ok   = (v.ack_at >= 0) && (v.ack_at < TO);
    load = v.rd && !v.wr;
    r.e_addr = v.addr - 32'(off);
    r.e_we   = v.wr;
    r.e_be   = v.wr ? 4'(((1 << nb) - 1) << off) : 4'd0;
    r.e_wd   = (nb == 4) ? v.rt :
               (nb == 2) ? (v.rt % 65536) * 32'h0001_0001 :
                           (v.rt % 256) * 32'h0101_0101;
    r.e_stall = mis ? 1 : ok ? v.ack_at + 2 : TO + 1;
    r.e_req   = mis ? 0 : ok ? v.ack_at + 1 : TO;
    r.e_rv    = !mis && ok && load;
    r.e_merr  = mis;
    r.e_terr  = !mis && !ok;
    lim = longint'(1) << (8 * nb);
    raw = longint'(v.rdata >> (8 * off)) % lim;
    if (v.mas && nb < 4 && raw >= lim / 2) raw = raw + 64'h1_0000_0000 - lim;
    if (mis || r.e_terr)   r.e_rdout = 32'd0;
    else if (r.e_rv)       r.e_rdout = 32'(raw);
    else                   r.e_rdout = prev;
    return r;
  endfunction

  task automatic run_op(input string tag, input vec_t v);
    int  stall_n, req_n;
    bit  fields_ok, done_seen;
    MEM_MemRead  = v.rd;
    MEM_MemWrite = v.wr;
    MEM_BitsIn   = v.bits;
    MEM_MAS      = v.mas;
    MEM_Address  = v.addr;
    MEM_Rt       = v.rt;
    if (in_done) begin
      @(posedge Clk); #1;
    end else begin
      #1;
    end
    stall_n = 0; req_n = 0; fields_ok = 1'b1; done_seen = 1'b0;
    for (int g = 0; g < TO + 6 && !done_seen; g++) begin
      if (Stall) begin
        stall_n++;
        if (DM_Req) begin
          req_n++;
          if (DM_We !== v.e_we || DM_Addr !== v.e_addr || DM_ByteEn !== v.e_be) fields_ok = 1'b0;
          if (v.e_we && DM_WData !== v.e_wd) fields_ok = 1'b0;
          if (req_n - 1 == v.ack_at) begin
            DM_Ack   = 1'b1;
            DM_RData = v.rdata;
          end
        end
        @(posedge Clk); #1;
        DM_Ack   = 1'b0;
        DM_RData = $urandom;
      end else begin
        done_seen = 1'b1;
      end
    end
    check({tag, " done_reached"}, 32'(done_seen), 32'd1);
    check({tag, " stall_cycles"}, stall_n, v.e_stall);
    check({tag, " req_cycles"}, req_n, v.e_req);
    if (req_n > 0) check({tag, " req_fields"}, 32'(fields_ok), 32'd1);
    check({tag, " req_low_in_done"}, 32'(DM_Req), 32'd0);
    check({tag, " read_valid"}, 32'(MEM_ReadValid), 32'(v.e_rv));
    check({tag, " misalign_err"}, 32'(MisalignErr), 32'(v.e_merr));
    check({tag, " timeout_err"}, 32'(TimeoutErr), 32'(v.e_terr));
    check({tag, " read_data"}, MEM_ReadData, v.e_rdout);
    exp_rdout = v.e_rdout;
    in_done = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int r;
    //          rd    wr    bits   mas   addr          rt            rdata         ack | e_addr        we    be      wd            st rq rv    merr  terr  rdout
    tbl[0]  = '{1'b1, 1'b0, 2'b10, 1'b1, 32'h0000_1003, 32'h0,        32'h8012_3456, 0, 32'h0000_1000, 1'b0, 4'h0, 32'h0,        2, 1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FF80};
    tbl[1]  = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'hDEAD_BEEF, 32'h0,       2, 32'h0000_2000, 1'b1, 4'hC, 32'hBEEF_BEEF, 4, 3, 1'b0, 1'b0, 1'b0, 32'hFFFF_FF80};
    tbl[2]  = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0001, 32'h0,        32'h0,         0, 32'h0,         1'b0, 4'h0, 32'h0,        1, 0, 1'b0, 1'b1, 1'b0, 32'h0};
    tbl[3]  = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0040, 32'h0,        32'h0,        -1, 32'h0000_0040, 1'b0, 4'h0, 32'h0,        5, 4, 1'b0, 1'b0, 1'b1, 32'h0};
    tbl[4]  = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0010, 32'h0,        32'h1122_3344, 0, 32'h0000_0010, 1'b0, 4'h0, 32'h0,        2, 1, 1'b1, 1'b0, 1'b0, 32'h1122_3344};
    tbl[5]  = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0011, 32'h0000_00A5, 32'h0,       1, 32'h0000_0010, 1'b1, 4'h2, 32'hA5A5_A5A5, 3, 2, 1'b0, 1'b0, 1'b0, 32'h1122_3344};
    tbl[6]  = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0002, 32'h0,        32'h8001_7FFF, 0, 32'h0,         1'b0, 4'h0, 32'h0,        2, 1, 1'b1, 1'b0, 1'b0, 32'h0000_8001};
    tbl[7]  = '{1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0000, 32'h0,        32'h1234_8000, 1, 32'h0,         1'b0, 4'h0, 32'h0,        3, 2, 1'b1, 1'b0, 1'b0, 32'hFFFF_8000};
    tbl[8]  = '{1'b0, 1'b1, 2'b11, 1'b0, 32'h0000_0100, 32'hCAFE_F00D, 32'h0,       0, 32'h0000_0100, 1'b1, 4'hF, 32'hCAFE_F00D, 2, 1, 1'b0, 1'b0, 1'b0, 32'hFFFF_8000};
    tbl[9]  = '{1'b1, 1'b1, 2'b00, 1'b0, 32'h0000_0204, 32'h0102_0304, 32'hFFFF_FFFF, 0, 32'h0000_0204, 1'b1, 4'hF, 32'h0102_0304, 2, 1, 1'b0, 1'b0, 1'b0, 32'hFFFF_8000};
    tbl[10] = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0003, 32'h0,        32'h0,         0, 32'h0,         1'b1, 4'h0, 32'h0,        1, 0, 1'b0, 1'b1, 1'b0, 32'h0};
    tbl[11] = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0001, 32'h0,        32'h0000_9A00, 0, 32'h0,         1'b0, 4'h0, 32'h0,        2, 1, 1'b1, 1'b0, 1'b0, 32'h0000_009A};
    tbl[12] = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0300, 32'h0,        32'h5566_7788, 3, 32'h0000_0300, 1'b0, 4'h0, 32'h0,        5, 4, 1'b1, 1'b0, 1'b0, 32'h5566_7788};

    Reset = 1'b1;
    MEM_MemRead = 1'b0; MEM_MemWrite = 1'b0; MEM_BitsIn = 2'b00; MEM_MAS = 1'b0;
    MEM_Address = 32'd0; MEM_Rt = 32'd0; DM_RData = 32'd0; DM_Ack = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    check("reset stall", 32'(Stall), 32'd0);
    check("reset req", 32'(DM_Req), 32'd0);
    check("reset read_data", MEM_ReadData, 32'd0);
    check("reset flags", {29'd0, MEM_ReadValid, MisalignErr, TimeoutErr}, 32'd0);
    Reset = 1'b0;

    for (int i = 0; i < 13; i++) run_op($sformatf("vec%0d", i), tbl[i]);

    // Reset in the middle of an ACCESS, then a late Ack in IDLE.
    MEM_MemRead = 1'b1; MEM_MemWrite = 1'b0; MEM_BitsIn = 2'b00; MEM_Address = 32'h0000_0080;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    check("rst_mid req_before", 32'(DM_Req), 32'd1);
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    check("rst_mid req", 32'(DM_Req), 32'd0);
    check("rst_mid stall_op", 32'(Stall), 32'd1);
    check("rst_mid dm_regs", {DM_We, DM_ByteEn} | DM_Addr | DM_WData, 32'd0);
    check("rst_mid read_data", MEM_ReadData, 32'd0);
    check("rst_mid flags", {29'd0, MEM_ReadValid, MisalignErr, TimeoutErr}, 32'd0);
    MEM_MemRead = 1'b0; DM_Ack = 1'b1; DM_RData = 32'h1234_5678;
    #1;
    check("rst_mid stall_noop", 32'(Stall), 32'd0);
    @(posedge Clk); #1;
    DM_Ack = 1'b0;
    check("rst_mid late_ack", {30'd0, MEM_ReadValid, DM_Req}, 32'd0);
    in_done = 1'b0;
    exp_rdout = 32'd0;

    // Timeout, then Acks arriving in DONE and IDLE must be ignored.
    v = '0;
    v.rd = 1'b1; v.addr = 32'h0000_0500; v.ack_at = -1;
    run_op("timeout", model(v, exp_rdout));
    MEM_MemRead = 1'b0; DM_Ack = 1'b1;
    @(posedge Clk); #1;
    check("late_ack idle_stall", 32'(Stall), 32'd0);
    check("late_ack idle", {30'd0, MEM_ReadValid, DM_Req}, 32'd0);
    @(posedge Clk); #1;
    DM_Ack = 1'b0;
    check("late_ack idle2", {30'd0, MEM_ReadValid, DM_Req}, 32'd0);
    check("late_ack read_data", MEM_ReadData, 32'd0);
    in_done = 1'b0;

    for (int i = 0; i < 80; i++) begin
      v = '0;
      r = $urandom_range(1, 3);
      v.rd    = r[0];
      v.wr    = r[1];
      v.bits  = 2'($urandom_range(0, 3));
      v.mas   = 1'($urandom_range(0, 1));
      v.addr  = $urandom;
      if ($urandom_range(0, 1) == 1) v.addr[1:0] = 2'b00;
      v.rt    = $urandom;
      v.rdata = $urandom;
      v.ack_at = $urandom_range(0, 5);
      if (v.ack_at == 5) v.ack_at = -1;
      run_op($sformatf("rand%0d", i), model(v, exp_rdout));
    end

    MEM_MemRead = 1'b0; MEM_MemWrite = 1'b0;
    @(posedge Clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
